// File: rtl/data_inf_c_s2m_credit_dispatch.sv
// Packet-level destination scheduler: round-robin pick among enabled destinations holding credits,
// addr held for the whole packet, one credit consumed per packet and returned by pulses.
`timescale 1ns/1ps
module data_inf_c_s2m_credit_dispatch #(
   parameter int unsigned NUM        = 8,
   parameter int unsigned DSIZE      = 8,
   parameter int unsigned CREDIT_MAX = 4,
   parameter int unsigned NSIZE      = $clog2(NUM),
   parameter int unsigned CSIZE      = $clog2(CREDIT_MAX + 1)
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [NUM-1:0]   dest_en,
   input  logic [NUM-1:0]   credit_rtn,
   input  logic             in_valid,
   input  logic [DSIZE-1:0] in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   input  logic             out_ready,
   output logic [NSIZE-1:0] addr,
   output logic             credit_err
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t           state;
   logic [CSIZE-1:0] credit [NUM];
   logic [NSIZE-1:0] rr_ptr;
   logic [NSIZE-1:0] pick;
   logic [NSIZE-1:0] idx;
   logic [NUM-1:0]   eligible;
   logic [NUM-1:0]   consume;
   logic             found;
   logic             start;
   logic             done;

   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NUM; i++)
         eligible[i] = dest_en[i] && (credit[i] != '0);
   end

   // First eligible destination scanning upward from rr_ptr with wrap-around.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int unsigned k = 0; k < NUM; k++) begin
         idx = NSIZE'((32'(rr_ptr) + k) % NUM);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign start = (state == IDLE) && in_valid && found;
   assign done  = (state == SEND) && in_valid && out_ready && in_last;

   always_comb begin
      consume = '0;
      for (int unsigned i = 0; i < NUM; i++)
         consume[i] = start && (pick == NSIZE'(i));
   end

   assign out_valid = (state == SEND) && in_valid;
   assign in_ready  = (state == SEND) && out_ready;
   assign out_data  = in_data;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr       <= '0;
         rr_ptr     <= '0;
         credit_err <= 1'b0;
         for (int unsigned i = 0; i < NUM; i++)
            credit[i] <= CSIZE'(CREDIT_MAX);
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr  <= pick;
                  state <= SEND;
               end
            end
            SEND: begin
               if (done) begin
                  rr_ptr <= (addr == NSIZE'(NUM - 1)) ? '0 : addr + 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Simultaneous consume and return on one destination cancel out.
         for (int unsigned i = 0; i < NUM; i++) begin
            if (consume[i] && !credit_rtn[i])
               credit[i] <= credit[i] - 1'b1;
            else if (credit_rtn[i] && !consume[i]) begin
               if (credit[i] == CSIZE'(CREDIT_MAX))
                  credit_err <= 1'b1;
               else
                  credit[i] <= credit[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_inf_c_s2m_credit_dispatch.sv
// Directed bench for the credit dispatcher (NUM=4, CREDIT_MAX=2): scoreboard of expected
// addr/data per beat, popped on each observed out_valid&out_ready handshake.
`timescale 1ns/1ps
module tb_data_inf_c_s2m_credit_dispatch;

   logic       clock = 1'b0;
   logic       rst_n;
   logic [3:0] dest_en;
   logic [3:0] credit_rtn;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [1:0] addr;
   logic       credit_err;

   data_inf_c_s2m_credit_dispatch #(
      .NUM        (4),
      .DSIZE      (8),
      .CREDIT_MAX (2)
   ) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .dest_en    (dest_en),
      .credit_rtn (credit_rtn),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .addr       (addr),
      .credit_err (credit_err)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0] a;
      logic [7:0] d;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   bit         tog    = 1'b0;
   logic [7:0] seq    = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL beat_unexpected observed addr=%0h data=%0h expected=none", addr, out_data);
         end else begin
            e = sb.pop_front();
            chk("beat_addr", 32'(addr), 32'(e.a));
            chk("beat_data", 32'(out_data), 32'(e.d));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the beat's handshake edge.
   task automatic beat(input logic [1:0] a, input logic last, output int waited);
      seq++;
      sb.push_back('{a: a, d: seq});
      in_valid = 1'b1;
      in_data  = seq;
      in_last  = last;
      waited   = 0;
      forever begin
         if (tog) out_ready = ~out_ready;
         @(negedge clock);
         if (in_ready === 1'b1) break;
         waited++;
         if (waited > 40) begin
            checks++;
            errors++;
            $error("FAIL beat_timeout observed=no_in_ready expected=in_ready addr=%0h", a);
            break;
         end
         @(posedge clock);
         #1;
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pkt(input logic [1:0] a, input int n, input bit t);
      int w;
      tog = t;
      for (int b = 0; b < n; b++) begin
         beat(a, (b == n - 1), w);
         if (!t) chk("beat_latency", 32'(w), (b == 0) ? 32'd1 : 32'd0);
      end
      tog       = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic stall(input int n);
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 8'hEE;
      repeat (n) begin
         @(negedge clock);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      @(posedge clock);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int w;
      rst_n      = 1'b0;
      dest_en    = 4'b1111;
      credit_rtn = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_last    = 1'b0;
      out_ready  = 1'b1;

      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_credit_err", 32'(credit_err), 32'd0);
      @(posedge clock);
      #1;
      rst_n = 1'b1;

      // Eight single-beat packets drain two credits from each destination.
      for (int i = 0; i < 8; i++) pkt(2'(i % 4), 1, 1'b0);
      stall(4);

      // A return on dest 2 releases the waiting packet there.
      credit_rtn = 4'b0100;
      @(posedge clock);
      #1;
      credit_rtn = '0;
      pkt(2'd2, 1, 1'b0);

      reset_pulse();
      dest_en = 4'b1010;
      pkt(2'd1, 4, 1'b0);
      pkt(2'd3, 4, 1'b1);
      pkt(2'd1, 4, 1'b0);
      pkt(2'd3, 4, 1'b0);
      stall(3);
      in_valid = 1'b0;

      // Return into a full counter.
      credit_rtn = 4'b0001;
      @(posedge clock);
      #1;
      credit_rtn = '0;
      @(negedge clock);
      chk("credit_err_set", 32'(credit_err), 32'd1);
      repeat (3) @(negedge clock);
      chk("credit_err_sticky", 32'(credit_err), 32'd1);
      @(posedge clock);
      #1;
      dest_en = 4'b0001;
      pkt(2'd0, 1, 1'b0);
      pkt(2'd0, 1, 1'b0);
      stall(3);
      in_valid = 1'b0;

      // Same-cycle consume and return on dest 1 leaves its single credit intact.
      credit_rtn = 4'b0010;
      @(posedge clock);
      #1;
      dest_en    = 4'b0010;
      credit_rtn = 4'b0010;
      fork
         beat(2'd1, 1'b1, w);
         begin
            @(posedge clock);
            #1;
            credit_rtn = '0;
         end
      join
      chk("same_cycle_latency", 32'(w), 32'd1);
      pkt(2'd1, 1, 1'b0);
      stall(3);
      in_valid = 1'b0;
      chk("credit_err_kept", 32'(credit_err), 32'd1);

      // Partial packet to dest 2, valid gap, then reset mid-packet.
      dest_en = 4'b1111;
      beat(2'd2, 1'b0, w);
      chk("mid_first_latency", 32'(w), 32'd1);
      beat(2'd2, 1'b0, w);
      chk("mid_second_latency", 32'(w), 32'd0);
      @(negedge clock);
      chk("gap_out_valid", 32'(out_valid), 32'd0);
      chk("gap_addr", 32'(addr), 32'd2);
      chk("gap_in_ready", 32'(in_ready), 32'd1);
      @(posedge clock);
      #1;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      rst_n    = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_addr", 32'(addr), 32'd0);
      chk("midrst_credit_err", 32'(credit_err), 32'd0);
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) pkt(2'(i % 4), 1, 1'b0);
      stall(3);
      in_valid = 1'b0;

      repeat (2) @(posedge clock);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
